uart_rx_path: RTL
=================

Name: uart_rx_path

Overview:
UART receive path. It is the far-end counterpart of the team's Tx path and decodes the same serial frame: start 0, WIDTH_SIZE data bits LSB-first, even-parity bit(s), stop 1. It deserialises the line into a parallel word and checks parity and stop bit. The word is held in a one-entry output register behind a valid/ready handshake, with overrun detection. It sits between the serial pin and the core-side consumer.

Parameters:
WIDTH_SIZE, 8, data bits per frame (1..32).
CLKS_PER_BIT, 1, clk cycles per serial bit (1..255); bits are sampled mid-bit when >1.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
rx  in  1  serial line, idle high
PF  in  1  parity mode: 1 = parity bit after every 8-bit group (last group may be partial); 0 = single parity bit after all data
rx_ready  in  1  consumer accepts word
rx_data  out  WIDTH_SIZE  received word
rx_valid  out  1  rx_data/flags valid
parity_err  out  1  one or more parity groups mismatched
frame_err  out  1  stop bit sampled 0
overrun  out  1  sticky: a frame completed while rx_valid was high and rx_ready was low

Behaviour:
- Reset: reset asynchronous, active-high; clock clk. All outputs 0; FSM goes to IDLE; counters 0.
- States (uart_pkg::rx_state_t): IDLE, START, DATA, PARITY, STOP.
- IDLE: on rx==0, capture PF and go to START.
  - CLKS_PER_BIT==1: that sample is the start bit; go to DATA next edge.
  - CLKS_PER_BIT>1: wait CLKS_PER_BIT/2 clocks and re-sample. rx==1 means a glitch: return to IDLE, no output.
- Sampling: subsequent samples every CLKS_PER_BIT clocks.
- DATA: shift the sample into bit index (LSB first) and XOR it into the running parity.
  - PF=1 with 8 bits accumulated in the group, or all WIDTH_SIZE bits received: go to PARITY.
- PARITY: compare sample to the accumulated even parity (XOR of the group's data bits); a mismatch sets the internal err.
  - Clear the group parity. Return to DATA if bits remain, else go to STOP.
  - PF=0: exactly one PARITY, after all bits.
- Parity bit count: PF ? ceil(WIDTH_SIZE/8) : 1. With WIDTH_SIZE<=8, both modes are identical.
- STOP: sample the stop bit and go to IDLE; the next start can be detected on the following sample.
  - Output register empty, or rx_valid&&rx_ready in this same cycle: load rx_data, parity_err, frame_err(=~rx) and set rx_valid.
  - Otherwise: drop the new frame, keep the old word and flags, set overrun.
- Latency: rx_valid is high in the cycle after the clock edge that samples the stop bit. Frame length is (2 + WIDTH_SIZE + parity count) × CLKS_PER_BIT clocks.
- Handshake: rx_valid stays high until a cycle with rx_ready=1; it deasserts the next cycle unless a new word loads in that same cycle.
  - overrun clears on an accepted handshake.
  - parity_err and frame_err are meaningful only while rx_valid is high.
- Frame error: the word is still delivered. The FSM returns to IDLE, and rx low at that point begins a new start detection.
- Mid-frame reset aborts the partial frame and clears all state.

Optional Feature:
RX_SYNC_EN
- Defined: rx passes through a 2-flop synchroniser (reset value 1) before the FSM. All latencies grow by 2 clocks.
- Undefined: rx is used directly; the bench drives it synchronously.

Decomposition:
- uart_pkg: rx_state_t enum, PARITY_GROUP = 8, function parity_bits(width, pf).
- One sub-module, uart_bit_timer. Inputs: start, CLKS_PER_BIT. Outputs: sample_tick (first tick at half period, then every full period) and a restart. It is shared with a future baud-divided Tx.

Test Plan:
1. WIDTH_SIZE=8, CLKS_PER_BIT=1. Send 0xA5 (rx: 0,1,0,1,0,0,1,0,1,parity 0,stop 1), rx_ready=1 → rx_data=0xA5, rx_valid 1 cycle, 11 cycles after start, no errors.
2. Same as 1, but parity bit 1 (the Tx err injection) → rx_data=0xA5, parity_err=1, frame_err=0.
3. Same as 1, but stop bit 0 → frame_err=1, rx_data=0xA5. A following valid frame 0x3C is received correctly.
4. WIDTH_SIZE=16, PF=1. Send 0x12F0: start, low byte 0xF0, parity 0, high byte 0x12, parity 0, stop (20 bits) → rx_data=0x12F0, no errors. Then PF=0, same data with a single parity 0 → same result, 19 bits.
5. rx_ready=0, two back-to-back frames 0x11 then 0x22 → rx_data stays 0x11, overrun=1. Raise rx_ready → accepted, overrun clears.
6. CLKS_PER_BIT=4, 1-cycle low glitch on rx → no rx_valid, FSM back to IDLE. Then a full frame 0x5A → rx_data=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity grouping and frame helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int unsigned PARITY_GROUP = 8;

    // Number of parity bits in a frame: one per 8-bit group, or one in total.
    function automatic int unsigned parity_bits(input int unsigned width, input logic pf);
        return pf ? (width + PARITY_GROUP - 1) / PARITY_GROUP : 1;
    endfunction

endpackage

// File: rtl/uart_rx_path_if.sv
// Core-side word handshake of the UART receive path; master is the receiver.
interface uart_rx_path_if #(
    parameter int unsigned WIDTH_SIZE = 8
) ();

    logic [WIDTH_SIZE-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: after start, first tick at half a period, then every full period.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic sample_tick,
    output logic restart
);

    localparam int unsigned HALF      = CLKS_PER_BIT / 2;
    localparam logic [7:0]  HALF_LOAD = (HALF == 0) ? 8'd0 : 8'(HALF - 1);
    localparam logic [7:0]  FULL_LOAD = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt;
    logic       first;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            first <= 1'b0;
        end else if (start) begin
            cnt   <= HALF_LOAD;
            first <= 1'b1;
        end else if (cnt == '0) begin
            cnt   <= FULL_LOAD;
            first <= 1'b0;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign sample_tick = (cnt == '0);
    // High while the half-period tick that follows a start is still pending.
    assign restart     = first;

endmodule

// File: rtl/uart_rx_path.sv
// UART receive path: start, data LSB-first, even parity (per byte or whole word), stop.
// Optional RX_SYNC_EN adds a 2-flop input synchroniser in front of the FSM.
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH_SIZE   = 8,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic PF,
    uart_rx_path_if.master core
);

    localparam int unsigned BW = $clog2(WIDTH_SIZE + 1);
    localparam int unsigned GW = $clog2(PARITY_GROUP + 1);

    logic rx_line;

`ifdef RX_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '1;
        else       sync <= {sync[0], rx};
    end
    assign rx_line = sync[1];
`else
    assign rx_line = rx;
`endif

    rx_state_t state, next;

    logic          tick, first;
    logic          timer_start, frame_clr, shift_en, par_en, stop_en;
    logic [BW-1:0] bit_cnt;
    logic [GW-1:0] grp_cnt;
    logic          gpar, err, pf_q;
    logic          last_bit, grp_full;

    logic [WIDTH_SIZE-1:0] shreg;
    logic [WIDTH_SIZE:0]   shext;

    logic [WIDTH_SIZE-1:0] data_q;
    logic                  valid_q, perr_q, ferr_q, overrun_q;
    logic                  accept, load;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) timer (
        .clk        (clk),
        .reset      (reset),
        .start      (timer_start),
        .sample_tick(tick),
        .restart    (first)
    );

    assign last_bit = (bit_cnt == BW'(WIDTH_SIZE - 1));
    assign grp_full = (grp_cnt == GW'(PARITY_GROUP - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next        = state;
        timer_start = 1'b0;
        frame_clr   = 1'b0;
        shift_en    = 1'b0;
        par_en      = 1'b0;
        stop_en     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_line) begin
                    frame_clr   = 1'b1;
                    timer_start = 1'b1;
                    // With one clock per bit the detecting sample is already the start bit.
                    next        = (CLKS_PER_BIT == 1) ? DATA : START;
                end
            end
            START: begin
                if (tick && first) next = rx_line ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (last_bit || (pf_q && grp_full)) next = PARITY;
                end
            end
            PARITY: begin
                if (tick) begin
                    par_en = 1'b1;
                    next   = (bit_cnt == BW'(WIDTH_SIZE)) ? STOP : DATA;
                end
            end
            STOP: begin
                if (tick) begin
                    stop_en = 1'b1;
                    next    = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    assign shext = {rx_line, shreg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            grp_cnt <= '0;
            gpar    <= 1'b0;
            err     <= 1'b0;
            pf_q    <= 1'b0;
        end else begin
            if (frame_clr) begin
                bit_cnt <= '0;
                grp_cnt <= '0;
                gpar    <= 1'b0;
                err     <= 1'b0;
                pf_q    <= PF;
            end
            if (shift_en) begin
                shreg   <= shext[WIDTH_SIZE:1];
                bit_cnt <= bit_cnt + BW'(1);
                grp_cnt <= grp_cnt + GW'(1);
                gpar    <= gpar ^ rx_line;
            end
            if (par_en) begin
                if (rx_line != gpar) err <= 1'b1;
                gpar    <= 1'b0;
                grp_cnt <= '0;
            end
        end
    end

    assign accept = valid_q && core.rx_ready;
    // A finished frame may replace the held word only if it is empty or leaving this cycle.
    assign load   = stop_en && (!valid_q || accept);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (load) begin
                data_q  <= shreg;
                perr_q  <= err;
                ferr_q  <= ~rx_line;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
            if (stop_en && !load) overrun_q <= 1'b1;
            else if (accept)      overrun_q <= 1'b0;
        end
    end

    assign core.rx_data    = data_q;
    assign core.rx_valid   = valid_q;
    assign core.parity_err = perr_q;
    assign core.frame_err  = ferr_q;
    assign core.overrun    = overrun_q;

endmodule
